// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, instruction
// word field positions and the special selector/halt encodings.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CFETCH,
    S_ISSUE,
    S_HALT
  } state_e;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 29;
  localparam int unsigned FORM_BIT = 28;
  localparam int unsigned VEC_MSB  = 27;
  localparam int unsigned VEC_LSB  = 26;
  localparam int unsigned A_MSB    = 25;
  localparam int unsigned A_LSB    = 22;
  localparam int unsigned B_MSB    = 21;
  localparam int unsigned B_LSB    = 18;
  localparam int unsigned C_MSB    = 17;
  localparam int unsigned C_LSB    = 14;
  localparam int unsigned D_MSB    = 13;
  localparam int unsigned D_LSB    = 10;
  localparam int unsigned Y1_MSB   = 9;
  localparam int unsigned Y1_LSB   = 6;
  localparam int unsigned Y2_MSB   = 5;
  localparam int unsigned Y2_LSB   = 2;
  localparam int unsigned WR_MSB   = 1;
  localparam int unsigned WR_LSB   = 0;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [3:0]  CONST_SEL = 4'hF;
  localparam logic [3:0]  ZERO_SEL  = 4'h0;

  // Decoded fields that persist on the outputs between issues.
  typedef struct packed {
    logic [2:0] op;
    logic       form;
    logic [1:0] vec;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] y1;
    logic [3:0] y2;
  } fields_t;

endpackage

// File: rtl/instr_sequencer_fields.sv
// Purely combinational split of one instruction word into its fields,
// plus the zero-register, constant-operand and halt-word flags.
module instr_fields
  import instr_sequencer_pkg::*;
(
  input  logic [31:0] word_i,
  output fields_t     fields_o,
  output logic [1:0]  write_o,
  output logic [3:0]  zero_reg_o,
  output logic        const_a_o,
  output logic        is_halt_o
);

  always_comb begin
    fields_o.op   = word_i[OP_MSB:OP_LSB];
    fields_o.form = word_i[FORM_BIT];
    fields_o.vec  = word_i[VEC_MSB:VEC_LSB];
    fields_o.a    = word_i[A_MSB:A_LSB];
    fields_o.b    = word_i[B_MSB:B_LSB];
    fields_o.c    = word_i[C_MSB:C_LSB];
    fields_o.d    = word_i[D_MSB:D_LSB];
    fields_o.y1   = word_i[Y1_MSB:Y1_LSB];
    fields_o.y2   = word_i[Y2_MSB:Y2_LSB];
    write_o       = word_i[WR_MSB:WR_LSB];
  end

  assign zero_reg_o[0] = (word_i[A_MSB:A_LSB] == ZERO_SEL);
  assign zero_reg_o[1] = (word_i[B_MSB:B_LSB] == ZERO_SEL);
  assign zero_reg_o[2] = (word_i[C_MSB:C_LSB] == ZERO_SEL);
  assign zero_reg_o[3] = (word_i[D_MSB:D_LSB] == ZERO_SEL);

  assign const_a_o = (word_i[A_MSB:A_LSB] == CONST_SEL) && !zero_reg_o[0];
  assign is_halt_o = (word_i == HALT_WORD);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer: fetches one- or two-word instructions over a
// req/ack memory port and presents decoded controls for a single ISSUE cycle.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] start_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [2:0]  op,
  output logic        form,
  output logic [1:0]  vec,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  output logic [3:0]  Y1,
  output logic [3:0]  Y2,
  output logic [3:0]  zero_reg,
  output logic [1:0]  write,
  output logic        const_a,
  output logic        program_counter_inc,
  output logic [31:0] constant,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] const_q, const_d;
  fields_t     fld_q, fld_d;
  logic [3:0]  zero_q, zero_d;
  logic        ca_q, ca_d;
  logic [1:0]  write_q, write_d;
  logic        inc_q, inc_d;

  logic [31:0] dec_word;
  fields_t     dec_fields;
  logic [1:0]  dec_write;
  logic [3:0]  dec_zero;
  logic        dec_const;
  logic        dec_halt;
  logic        load_issue;

  // During CFETCH the first word is already parked in instr_q; otherwise
  // decode straight off the memory bus in the ack cycle.
  assign dec_word = (state_q == S_CFETCH) ? instr_q : imem_data;

  instr_fields u_fields (
    .word_i     (dec_word),
    .fields_o   (dec_fields),
    .write_o    (dec_write),
    .zero_reg_o (dec_zero),
    .const_a_o  (dec_const),
    .is_halt_o  (dec_halt)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    const_d    = const_q;
    fld_d      = fld_q;
    zero_d     = zero_q;
    ca_d       = ca_q;
    write_d    = 2'b00;
    inc_d      = 1'b0;
    load_issue = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          pc_d    = start_pc;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (dec_halt) begin
            state_d = S_HALT;
          end else if (dec_const) begin
            state_d = S_CFETCH;
            instr_d = imem_data;
          end else begin
            state_d    = S_ISSUE;
            load_issue = 1'b1;
          end
        end
      end
      S_CFETCH: begin
        if (imem_ack) begin
          state_d    = S_ISSUE;
          const_d    = imem_data;
          load_issue = 1'b1;
        end
      end
      S_ISSUE: begin
        pc_d    = pc_q + (ca_q ? 32'd2 : 32'd1);
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs change only on entry to ISSUE, so they hold across fetches.
    if (load_issue) begin
      fld_d   = dec_fields;
      zero_d  = dec_zero;
      ca_d    = dec_const;
      write_d = dec_write;
      inc_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= 32'h0;
      instr_q <= 32'h0;
      const_q <= 32'h0;
      fld_q   <= '0;
      zero_q  <= 4'h0;
      ca_q    <= 1'b0;
      write_q <= 2'b00;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      const_q <= const_d;
      fld_q   <= fld_d;
      zero_q  <= zero_d;
      ca_q    <= ca_d;
      write_q <= write_d;
      inc_q   <= inc_d;
    end
  end

  assign imem_req  = (state_q == S_FETCH) || (state_q == S_CFETCH);
  assign imem_addr = (state_q == S_CFETCH) ? (pc_q + 32'd1) : pc_q;
  assign halted    = (state_q == S_HALT);

  assign op                  = fld_q.op;
  assign form                = fld_q.form;
  assign vec                 = fld_q.vec;
  assign A                   = fld_q.a;
  assign B                   = fld_q.b;
  assign C                   = fld_q.c;
  assign D                   = fld_q.d;
  assign Y1                  = fld_q.y1;
  assign Y2                  = fld_q.y2;
  assign zero_reg            = zero_q;
  assign write               = write_q;
  assign const_a             = ca_q;
  assign program_counter_inc = inc_q;
  assign constant            = const_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a table of single instructions run
// against a modelled memory, plus hand-written multi-cycle sequences.
module tb_instr_sequencer;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [31:0] start_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic [2:0]  op;
  logic        form;
  logic [1:0]  vec;
  logic [3:0]  A, B, C, D, Y1, Y2, zero_reg;
  logic [1:0]  write;
  logic        const_a;
  logic        program_counter_inc;
  logic [31:0] constant;
  logic        halted;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .start_pc(start_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .op(op), .form(form), .vec(vec), .A(A), .B(B), .C(C), .D(D),
    .Y1(Y1), .Y2(Y2), .zero_reg(zero_reg), .write(write),
    .const_a(const_a), .program_counter_inc(program_counter_inc),
    .constant(constant), .halted(halted)
  );

  // Memory model: answers a held request after 'lat' extra cycles.
  logic [31:0] mem [logic [31:0]];
  bit          mem_en = 1'b1;
  int          lat = 0;
  int          wcnt = 0;
  logic        force_ack = 1'b0;
  logic [31:0] force_data = 32'h0;

  always @(negedge clk) begin
    if (!mem_en) begin
      imem_ack  = force_ack;
      imem_data = force_data;
    end else if (imem_req === 1'b1) begin
      if (wcnt >= lat) begin
        imem_ack  = 1'b1;
        imem_data = mem.exists(imem_addr) ? mem[imem_addr] : 32'h0;
        wcnt      = 0;
      end else begin
        imem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end
  end

  int checks = 0;
  int failures = 0;
  int issue_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (program_counter_inc === 1'b1) issue_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    step();
    step();
    rst = 1'b0;
    issue_cnt = 0;
  endtask

  task automatic wait_halt(input string name);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk(name, halted, 1);
  endtask

  function automatic logic [39:0] ctrl_vec();
    return {op, form, vec, A, B, C, D, Y1, Y2, zero_reg, write, const_a,
            program_counter_inc, imem_req, halted};
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [36:0] exp;        // {op,form,vec,A,B,C,D,Y1,Y2,zero_reg,write,const_a}
    logic [31:0] exp_const;
    logic [31:0] exp_next;
  } vec_t;

  vec_t tv [6];

  initial begin
    int n;
    logic ok;
    logic [31:0] a1, a2;

    tv[0] = '{32'h10, 32'h2C84_4246, HALT,
              {3'd1, 1'b0, 2'd3, 4'h2, 4'h1, 4'h1, 4'h0, 4'h9, 4'h1, 4'b1000, 2'b10, 1'b0},
              32'h0, 32'h11};
    tv[1] = '{32'h20, 32'h43CC_0001, 32'hDEAD_BEEF,
              {3'd2, 1'b0, 2'd0, 4'hF, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1100, 2'b01, 1'b1},
              32'hDEAD_BEEF, 32'h22};
    tv[2] = '{32'hFFFF_FFFF, 32'h43CC_0001, 32'h1234_5678,
              {3'd2, 1'b0, 2'd0, 4'hF, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1100, 2'b01, 1'b1},
              32'h1234_5678, 32'h1};
    tv[3] = '{32'h40, 32'h0000_0000, HALT,
              {3'd0, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1111, 2'b00, 1'b0},
              32'h0, 32'h41};
    tv[4] = '{32'h50, 32'hFFFF_FFFE, 32'h0000_0001,
              {3'd7, 1'b1, 2'd3, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0000, 2'b10, 1'b1},
              32'h1, 32'h52};
    tv[5] = '{32'h60, 32'hE03F_FFF3, HALT,
              {3'd7, 1'b0, 2'd0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hC, 4'b0001, 2'b11, 1'b0},
              32'h0, 32'h61};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      mem.delete();
      mem_en = 1'b1;
      lat    = 0;
      a1 = tv[i].pc + 32'd1;
      a2 = tv[i].pc + 32'd2;
      mem[tv[i].pc] = tv[i].w0;
      mem[a1]       = tv[i].w1;
      mem[a2]       = HALT;
      start_pc = tv[i].pc;
      run      = 1'b1;
      n = 0;
      step();
      while (program_counter_inc !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("v%0d_issue_seen", i), program_counter_inc, 1);
      chk($sformatf("v%0d_fields", i),
          {op, form, vec, A, B, C, D, Y1, Y2, zero_reg, write, const_a}, tv[i].exp);
      chk($sformatf("v%0d_constant", i), constant, tv[i].exp_const);
      step();
      chk($sformatf("v%0d_next_fetch", i), {imem_req, imem_addr}, {1'b1, tv[i].exp_next});
      chk($sformatf("v%0d_post_issue", i), {write, program_counter_inc, op},
          {2'b00, 1'b0, tv[i].exp[36:34]});
      wait_halt($sformatf("v%0d_halt", i));
      chk($sformatf("v%0d_issue_count", i), issue_cnt, 1);
    end

    // Reset clears everything, and wins over run.
    rst = 1'b1;
    run = 1'b1;
    step();
    step();
    chk("reset_ctrl", ctrl_vec(), 40'h0);
    chk("reset_const_addr", {constant, imem_addr}, 64'h0);
    rst = 1'b0;
    run = 1'b0;
    step();

    // Ack delayed by 3 cycles: request held stable for 4 cycles.
    do_reset();
    mem.delete();
    mem[32'h30] = 32'h2C84_4246;
    mem[32'h31] = HALT;
    lat = 3;
    start_pc = 32'h30;
    run = 1'b1;
    step();
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      if (!(imem_req === 1'b1 && imem_addr === 32'h30 && program_counter_inc === 1'b0)) ok = 1'b0;
    end
    chk("lat_req_hold", ok, 1);
    step();
    chk("lat_issue", {program_counter_inc, write, op}, {1'b1, 2'b10, 3'd1});
    wait_halt("lat_halt");
    chk("lat_issue_count", issue_cnt, 1);

    // Halt word at 0x5: never issued, sticky until reset.
    do_reset();
    mem.delete();
    mem[32'h5] = HALT;
    lat = 0;
    start_pc = 32'h5;
    run = 1'b1;
    wait_halt("halt_reach");
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) run = 1'b0;
      if (k == 7) run = 1'b1;
      step();
      if (!(halted === 1'b1 && imem_req === 1'b0)) ok = 1'b0;
    end
    chk("halt_sticky", ok, 1);
    chk("halt_no_issue", issue_cnt, 0);
    rst = 1'b1;
    run = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("halt_cleared", {halted, imem_req}, 2'b00);

    // Reset during FETCH with an ack under reset and a late ack after it.
    do_reset();
    mem_en = 1'b0;
    force_ack = 1'b0;
    start_pc = 32'h70;
    run = 1'b1;
    step();
    chk("mf_fetch", {imem_req, imem_addr}, {1'b1, 32'h70});
    rst = 1'b1;
    run = 1'b0;
    force_ack = 1'b1;
    force_data = 32'h2C84_4246;
    step();
    rst = 1'b0;
    step();
    force_ack = 1'b0;
    step();
    chk("mf_ctrl", ctrl_vec(), 40'h0);
    chk("mf_const_addr", {constant, imem_addr}, 64'h0);
    chk("mf_no_issue", issue_cnt, 0);
    mem_en = 1'b1;

    // Dropping run mid-fetch still completes and issues, then idles.
    do_reset();
    mem.delete();
    mem[32'h80] = 32'h2C84_4246;
    lat = 2;
    start_pc = 32'h80;
    run = 1'b1;
    step();
    run = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("rundrop_issue_count", issue_cnt, 1);
    chk("rundrop_idle", {imem_req, halted, op}, {1'b0, 1'b0, 3'd1});

    // Back-to-back one-word instructions with zero-wait memory.
    do_reset();
    mem.delete();
    for (int k = 0; k < 4; k++) begin
      a1 = 32'h90 + k;
      mem[a1] = 32'h0000_0001;
    end
    mem[32'h94] = HALT;
    lat = 0;
    start_pc = 32'h90;
    run = 1'b1;
    step();
    issue_cnt = 0;
    for (int k = 0; k < 8; k++) step();
    chk("thru_issue_count", issue_cnt, 4);
    wait_halt("thru_halt");
    chk("thru_halt_addr", imem_addr, 32'h94);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
